// File: rtl/sc_div_seq_pkg.sv
// Shared types, constants and helpers for the stochastic divider sequencer.
// Imported by the sequencer top and its LFSR sub-module.
package sc_div_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WARMUP,
        S_RUN,
        S_DONE
    } state_e;

    // x^8+x^6+x^5+x^4+1, Fibonacci form
    localparam logic [7:0] LFSR_TAPS  = 8'hB8;

    localparam logic [7:0] DEF_SEED_A = 8'h01;
    localparam logic [7:0] DEF_SEED_B = 8'h5A;
    localparam logic [7:0] DEF_SEED_C = 8'hA7;

    function automatic int cnt_width(input int len);
        return $clog2(len) + 1;
    endfunction

    function automatic logic [31:0] lfsr_step(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] mask;
        logic        fb;
        mask = (32'd1 << w) - 32'd1;
        fb   = ^(v & {24'd0, LFSR_TAPS});
        return ((v << 1) | {31'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Seeded Fibonacci LFSR; load (seed reload) takes priority over step.
// Never reaches the all-zero state from a nonzero seed.
module sc_lfsr
    import sc_div_seq_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] w_next;

    assign w_next = WIDTH'(lfsr_step(32'(r_val), WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= SEED;
        end else if (load) begin
            r_val <= SEED;
        end else if (step) begin
            r_val <= w_next;
        end
    end

    assign value = r_val;

endmodule

// File: rtl/sc_div_sequencer.sv
// Sequences one stochastic division on the shared regenerating SC divider:
// clear, warm-up, counted run, then a binary quotient over valid/ready.
module sc_div_sequencer
    import sc_div_seq_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               STREAM_LEN = 256,
    parameter int               WARMUP     = 16,
    parameter logic [WIDTH-1:0] SEED_A     = WIDTH'(DEF_SEED_A),
    parameter logic [WIDTH-1:0] SEED_B     = WIDTH'(DEF_SEED_B),
    parameter logic [WIDTH-1:0] SEED_C     = WIDTH'(DEF_SEED_C)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    input  logic             req_sel,
    input  logic             abort,
    output logic             dp_rst_n,
    output logic [WIDTH-1:0] dp_randnum,
    output logic             dp_sel,
    output logic             dp_dividend,
    output logic             dp_divisor,
    input  logic             dp_quotient,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_quotient,
    output logic             res_div0,
    output logic             res_sat
);

    localparam int CW = cnt_width(STREAM_LEN);
    localparam int PW = $clog2(WARMUP + STREAM_LEN + 1);
    localparam logic [PW-1:0] WARM_LAST = PW'(WARMUP - 1);
    localparam logic [PW-1:0] RUN_LAST  = PW'(STREAM_LEN - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic             r_sel;
    logic [PW-1:0]    r_phase;
    logic [CW-1:0]    r_count;
    logic             r_dp_rst_n;
    logic             r_dp_dividend;
    logic             r_dp_divisor;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_quotient;
    logic             r_res_div0;
    logic             r_res_sat;

    logic             w_div0;
    logic             w_accept;
    logic             w_load;
    logic             w_step;
    logic             w_cnt_en;
    logic             w_finish;
    logic             w_release;
    logic [WIDTH-1:0] w_lfsr_a;
    logic [WIDTH-1:0] w_lfsr_b;
    logic [WIDTH-1:0] w_lfsr_c;
    logic [WIDTH-1:0] w_nxt_a;
    logic [WIDTH-1:0] w_nxt_b;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH:0]   w_cnt_ext;

    assign w_div0 = (req_divisor == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_cnt_en    = 1'b0;
        w_finish    = 1'b0;
        w_release   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_div0 ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_phase == WARM_LAST) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // abort outranks the final counted cycle
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step   = 1'b1;
                    w_cnt_en = 1'b1;
                    if (r_phase == RUN_LAST) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (r_res_valid && res_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .value (w_lfsr_a)
    );

    sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .value (w_lfsr_b)
    );

    sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED_C)) u_lfsr_c (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .value (w_lfsr_c)
    );

    // Compare against the LFSR's next value so each bitstream bit lines up
    // with the randnum presented in the same cycle.
    assign w_nxt_a = WIDTH'(lfsr_step(32'(w_lfsr_a), WIDTH));
    assign w_nxt_b = WIDTH'(lfsr_step(32'(w_lfsr_b), WIDTH));

    assign w_cnt_nxt = r_count + CW'(dp_quotient);
    assign w_cnt_ext = (WIDTH+1)'(w_cnt_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_sel      <= 1'b0;
        end else if (w_accept) begin
            r_dividend <= req_dividend;
            r_divisor  <= req_divisor;
            r_sel      <= req_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_phase <= '0;
            r_count <= '0;
        end else if (w_step) begin
            if (r_state == S_WARMUP && r_phase == WARM_LAST) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PW'(1);
            end
            if (w_cnt_en) begin
                r_count <= w_cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_rst_n    <= 1'b1;
            r_dp_dividend <= 1'b0;
            r_dp_divisor  <= 1'b0;
        end else begin
            r_dp_rst_n <= (w_state_nxt != S_CLEAR);
            if (w_load) begin
                r_dp_dividend <= (r_dividend >= SEED_A);
                r_dp_divisor  <= (r_divisor >= SEED_B);
            end else if (w_step) begin
                r_dp_dividend <= (r_dividend >= w_nxt_a);
                r_dp_divisor  <= (r_divisor >= w_nxt_b);
            end
        end
    end

    // Divide-by-zero raises res_valid one edge after accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid    <= 1'b0;
            r_res_quotient <= '0;
            r_res_div0     <= 1'b0;
            r_res_sat      <= 1'b0;
        end else begin
            r_res_valid <= w_finish || (r_state == S_DONE && !w_release);
            if (w_accept && w_div0) begin
                r_res_quotient <= '1;
                r_res_div0     <= 1'b1;
                r_res_sat      <= 1'b0;
            end else if (w_finish) begin
                r_res_quotient <= w_cnt_ext[WIDTH] ? '1 : w_cnt_ext[WIDTH-1:0];
                r_res_div0     <= 1'b0;
                r_res_sat      <= (w_cnt_ext == {1'b1, {WIDTH{1'b0}}});
            end
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign dp_rst_n     = r_dp_rst_n;
    assign dp_randnum   = w_lfsr_c;
    assign dp_sel       = r_sel;
    assign dp_dividend  = r_dp_dividend;
    assign dp_divisor   = r_dp_divisor;
    assign res_valid    = r_res_valid;
    assign res_quotient = r_res_quotient;
    assign res_div0     = r_res_div0;
    assign res_sat      = r_res_sat;

endmodule

// File: tb/tb_sc_div_sequencer.sv
// Directed bench for sc_div_sequencer with a behavioural regenerating
// divider model on the datapath side and a software golden quotient.
module tb_sc_div_sequencer;

    localparam int W = 16;
    localparam int L = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_dividend = 8'h00;
    logic [7:0] req_divisor = 8'h00;
    logic       req_sel = 1'b0;
    logic       abort = 1'b0;
    logic       dp_rst_n;
    logic [7:0] dp_randnum;
    logic       dp_sel;
    logic       dp_dividend;
    logic       dp_divisor;
    logic       dp_quotient;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_quotient;
    logic       res_div0;
    logic       res_sat;

    int n_checks = 0;
    int n_err = 0;

    sc_div_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_sel      (req_sel),
        .abort        (abort),
        .dp_rst_n     (dp_rst_n),
        .dp_randnum   (dp_randnum),
        .dp_sel       (dp_sel),
        .dp_dividend  (dp_dividend),
        .dp_divisor   (dp_divisor),
        .dp_quotient  (dp_quotient),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_quotient (res_quotient),
        .res_div0     (res_div0),
        .res_sat      (res_sat)
    );

    always #5 clk = ~clk;

    // Datapath model: feedback estimator, q tracks dividend/divisor
    logic [7:0] m_est = 8'h80;
    logic       m_q;
    int         m_t;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;

    assign m_q = (m_est >= dp_randnum);
    assign dp_quotient = force_en ? force_val : m_q;

    always_comb begin
        m_t = int'(m_est) + int'(dp_dividend) - int'(m_q & dp_divisor);
        if (m_t < 0) m_t = 0;
        else if (m_t > 255) m_t = 255;
    end

    always_ff @(posedge clk) begin
        if (!dp_rst_n) m_est <= 8'h80;
        else m_est <= m_t[7:0];
    end

    function automatic logic [7:0] step8(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] golden(input logic [7:0] dvd,
                                          input logic [7:0] dsr);
        logic [7:0] la;
        logic [7:0] lb;
        logic [7:0] lc;
        logic       a;
        logic       b;
        logic       q;
        int         est;
        int         cnt;
        la = 8'h01;
        lb = 8'h5A;
        lc = 8'hA7;
        est = 128;
        cnt = 0;
        for (int j = 1; j <= W + L; j++) begin
            a = (dvd >= la);
            b = (dsr >= lb);
            q = (est >= int'(lc));
            if (j > W) cnt += int'(q);
            est = est + int'(a) - int'(q & b);
            if (est < 0) est = 0;
            else if (est > 255) est = 255;
            la = step8(la);
            lb = step8(lb);
            lc = step8(lc);
        end
        return (cnt >= 256) ? 8'hFF : 8'(cnt);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] dvd, input logic [7:0] dsr,
                        input logic sel, output int lat, output int rlow);
        int n;
        req_dividend = dvd;
        req_divisor = dsr;
        req_sel = sel;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 600) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        lat = 0;
        rlow = 0;
        while (!res_valid && lat < 400) begin
            if (!dp_rst_n) rlow++;
            tick();
            lat++;
        end
    endtask

    task automatic ack();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_flags"},
              32'({req_ready, res_valid, res_div0, res_sat,
                   dp_rst_n, dp_sel, dp_dividend, dp_divisor}),
              32'b1000_1000);
        check({tag, "_quot"}, 32'(res_quotient), 32'h00);
        check({tag, "_rand"}, 32'(dp_randnum), 32'hA7);
    endtask

    initial begin
        int         lat;
        int         rl;
        logic [7:0] g;
        logic       stable;
        logic       rdy_seen;
        logic       vld_seen;

        repeat (3) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        g = golden(8'h40, 8'h80);

        // normal division
        send(8'h40, 8'h80, 1'b1, lat, rl);
        check("t1_latency", 32'(lat), 32'd273);
        check("t1_quot", 32'(res_quotient), 32'(g));
        check("t1_range", 32'(res_quotient >= 8'h68 && res_quotient <= 8'h98),
              32'd1);
        check("t1_clear_cycles", 32'(rl), 32'd1);
        check("t1_div0_sat", 32'({res_div0, res_sat}), 32'd0);
        check("t1_sel", 32'(dp_sel), 32'd1);
        ack();
        check("t1_released", 32'({req_ready, res_valid}), 32'b10);

        // divide by zero
        send(8'h33, 8'h00, 1'b0, lat, rl);
        check("div0_latency", 32'(lat), 32'd1);
        check("div0_quot", 32'(res_quotient), 32'hFF);
        check("div0_flags", 32'({res_div0, res_sat}), 32'b10);
        check("div0_no_clear", 32'(rl), 32'd0);
        ack();

        // quotient stream all ones: saturation
        force_en = 1'b1;
        force_val = 1'b1;
        send(8'h40, 8'h80, 1'b0, lat, rl);
        check("ones_latency", 32'(lat), 32'd273);
        check("ones_quot", 32'(res_quotient), 32'hFF);
        check("ones_flags", 32'({res_div0, res_sat}), 32'b01);
        ack();

        // quotient stream all zeros, then hold the result
        force_val = 1'b0;
        send(8'h40, 8'h80, 1'b0, lat, rl);
        check("zeros_quot", 32'(res_quotient), 32'h00);
        check("zeros_flags", 32'({res_div0, res_sat}), 32'b00);
        req_dividend = 8'h40;
        req_divisor = 8'h80;
        req_sel = 1'b0;
        req_valid = 1'b1;
        stable = 1'b1;
        rdy_seen = 1'b0;
        repeat (10) begin
            tick();
            if (!res_valid || res_quotient !== 8'h00 || res_sat || res_div0)
                stable = 1'b0;
            if (req_ready) rdy_seen = 1'b1;
        end
        check("hold_stable", 32'(stable), 32'd1);
        check("hold_req_ready", 32'(rdy_seen), 32'd0);
        ack();
        check("ack_idle", 32'({req_ready, res_valid}), 32'b10);
        tick();
        req_valid = 1'b0;
        force_en = 1'b0;
        check("held_req_accepted", 32'({req_ready, dp_rst_n}), 32'b00);

        // abort on RUN cycle 100
        repeat (116) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 32'({req_ready, res_valid, dp_rst_n}), 32'b101);
        vld_seen = 1'b0;
        repeat (20) begin
            tick();
            if (res_valid) vld_seen = 1'b1;
        end
        check("abort_no_result", 32'(vld_seen), 32'd0);
        send(8'h40, 8'h80, 1'b1, lat, rl);
        check("after_abort_latency", 32'(lat), 32'd273);
        check("after_abort_quot", 32'(res_quotient), 32'(g));
        ack();

        // async reset during warm-up
        req_dividend = 8'h40;
        req_divisor = 8'h80;
        req_sel = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send(8'h40, 8'h80, 1'b1, lat, rl);
        check("after_reset_latency", 32'(lat), 32'd273);
        check("after_reset_quot", 32'(res_quotient), 32'(g));
        ack();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
